usb_tx_data_buffer: RTL and testbench
=====================================

// Module: usb_tx_data_buffer
// PURPOSE
//  - Byte FIFO directly upstream of usb_tx: the AHB slave side pushes payload bytes; usb_tx pops one byte per get_tx_packet_data.
//  - Supplies tx_packet_data (head byte) and tx_packet_data_size (current occupancy) to usb_tx.
//  - Holds at most one max-size full-speed data packet (64 bytes).
//  - Sticky overflow/underflow flags report host misuse.
// PARAMETERS
//  DEPTH   64  byte capacity; power of two, >= 2
//  DATA_W  8   byte width
// PORTS
//  clk                  in   1       system clock, all logic on rising edge
//  n_rst                in   1       synchronous active-low reset, sampled on rising clk
//  clear                in   1       flush buffer (host or controller abort)
//  store_tx_data        in   1       write strobe from AHB side, one byte per cycle
//  tx_data_in           in   DATA_W  byte to store
//  get_tx_packet_data   in   1       pop strobe from usb_tx
//  tx_packet_data       out  DATA_W  head-of-FIFO byte (first-word fall-through)
//  tx_packet_data_size  out  7       occupancy, 0..DEPTH ($clog2(DEPTH)+1 bits)
//  buffer_empty         out  1       occupancy == 0
//  buffer_full          out  1       occupancy == DEPTH
//  overflow_err         out  1       sticky: write attempted while full
//  underflow_err        out  1       sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (n_rst==0 at a rising edge): wptr=rptr=0; count=0; both err flags 0.
//    After reset: tx_packet_data=0, tx_packet_data_size=0, buffer_empty=1, buffer_full=0.
//    Storage array is not reset.
//  - Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH with no special case.
//    count is a separate register of width $clog2(DEPTH)+1.
//  - Priority per cycle: n_rst > clear > (write, read).
//  - clear: same effect as reset on pointers, count and err flags.
//    A store or get in the same cycle is discarded; no error is flagged.
//  - Write (store_tx_data & !full): mem[wptr]<=tx_data_in; wptr++.
//    Write while full: dropped; overflow_err<=1.
//  - Read (get_tx_packet_data & !empty): rptr++. The popped byte is the one on tx_packet_data in that same cycle.
//    The next byte is visible the following cycle.
//    Read while empty: ignored; underflow_err<=1.
//  - Simultaneous write+read:
//    - Not full, not empty: both happen; count unchanged.
//    - Empty: the write happens, the read is an underflow. The new byte is not visible until the next cycle.
//    - Full: the read happens, the write is an overflow. Full is evaluated on pre-cycle state.
//  - count: +1 on write only, -1 on read only, unchanged on both or neither. Never exceeds DEPTH and never goes below 0.
//  - tx_packet_data = empty ? 0 : mem[rptr]. This is a combinational read of registered state, with no added latency.
//  - tx_packet_data_size, buffer_empty and buffer_full are combinational from count.
//  - Err flags stay set until reset or clear. They do not block further operation.
//  - Store latency: a byte written at edge N is readable as head after edge N (if it was pushed to an empty FIFO).
// STRUCTURE
//  - usb_pkg: USB_MAX_PACKET_BYTES=64 (default for DEPTH).
//  - usb_pkg: typedef logic [7:0] usb_byte_t.
//  - usb_pkg: typedef logic [6:0] usb_pkt_size_t (type of tx_packet_data_size).
//  - Sub-module usb_fifo_ptr: wrapping pointer with enable and sync clear. Instantiated twice (wptr, rptr).
//  - Count logic and the storage array stay in the top module.
// TESTING
//  1 Reset: hold n_rst=0 two cycles -> size=0, empty=1, full=0, data=0x00, errs=0.
//  2 Store 0xA5,0x5A,0x3C back to back:
//    - size goes 1,2,3.
//    - Then 3 pops -> data reads A5,5A,3C in order, and empty=1 after the third pop.
//  3 Store 64 bytes 0x00..0x3F:
//    - full=1, size=64.
//    - 65th store (0xFF) -> overflow_err=1, size stays 64.
//    - Pop all 64 -> 0x00..0x3F, and 0xFF never appears.
//  4 With size=1 (head 0x11), store 0x22 and pop in the same cycle:
//    - Next cycle size=1, data=0x22.
//    - Then pop on empty -> underflow_err=1, data=0x00.
//  5 Wrap: store 60 bytes, pop 60, then store 10 (0xB0..0xB9):
//    - Pointers wrap past 63.
//    - Pops return 0xB0..0xB9, and size returns to 0.
//  6 Store 5 bytes with overflow_err set, then clear asserted together with a store:
//    - Next cycle size=0, empty=1, overflow_err=0, and the store is discarded.
//    - n_rst pulse during pops gives the same result.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB types and constants for the transmit path.
package usb_pkg;

  localparam int unsigned USB_MAX_PACKET_BYTES = 64;

  typedef logic [7:0] usb_byte_t;
  typedef logic [6:0] usb_pkt_size_t;

endpackage

// File: rtl/usb_fifo_ptr.sv
// Wrapping FIFO pointer with increment enable and synchronous clear.
module usb_fifo_ptr #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] ptr
);

  // Advance modulo 2**W; reset and clear both return to zero.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/usb_tx_data_buffer.sv
// Byte FIFO feeding usb_tx: first-word fall-through head, occupancy and
// sticky misuse flags.
module usb_tx_data_buffer
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH  = USB_MAX_PACKET_BYTES,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              store_tx_data,
  input  logic [DATA_W-1:0] tx_data_in,
  input  logic              get_tx_packet_data,
  output logic [DATA_W-1:0] tx_packet_data,
  output usb_pkt_size_t     tx_packet_data_size,
  output logic              buffer_empty,
  output logic              buffer_full,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic              do_wr;
  logic              do_rd;

  // Status from the registered occupancy; full/empty use pre-cycle state.
  always_comb begin
    buffer_empty        = (count == '0);
    buffer_full         = (count == CW'(DEPTH));
    tx_packet_data_size = usb_pkt_size_t'(count);
    do_wr               = store_tx_data && !buffer_full;
    do_rd               = get_tx_packet_data && !buffer_empty;
    tx_packet_data      = buffer_empty ? '0 : mem[rptr];
  end

  usb_fifo_ptr #(.W(AW)) u_wptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .en    (do_wr),
    .ptr   (wptr)
  );

  usb_fifo_ptr #(.W(AW)) u_rptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .en    (do_rd),
    .ptr   (rptr)
  );

  // Storage write; array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (n_rst && !clear && do_wr) begin
      mem[wptr] <= tx_data_in;
    end
  end

  // Occupancy: net change of the accepted write and read this cycle.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      count <= '0;
    end else if (do_wr && !do_rd) begin
      count <= count + CW'(1);
    end else if (do_rd && !do_wr) begin
      count <= count - CW'(1);
    end
  end

  // Sticky misuse flags, cleared only by reset or clear.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (store_tx_data && buffer_full) begin
        overflow_err <= 1'b1;
      end
      if (get_tx_packet_data && buffer_empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// Directed self-checking bench for usb_tx_data_buffer.
module tb_usb_tx_data_buffer;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       store_tx_data;
  logic [7:0] tx_data_in;
  logic       get_tx_packet_data;
  logic [7:0] tx_packet_data;
  logic [6:0] tx_packet_data_size;
  logic       buffer_empty;
  logic       buffer_full;
  logic       overflow_err;
  logic       underflow_err;

  int checks;
  int errors;

  usb_tx_data_buffer #(.DEPTH(64), .DATA_W(8)) dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .clear               (clear),
    .store_tx_data       (store_tx_data),
    .tx_data_in          (tx_data_in),
    .get_tx_packet_data  (get_tx_packet_data),
    .tx_packet_data      (tx_packet_data),
    .tx_packet_data_size (tx_packet_data_size),
    .buffer_empty        (buffer_empty),
    .buffer_full         (buffer_full),
    .overflow_err        (overflow_err),
    .underflow_err       (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    store_tx_data      = 1'b0;
    get_tx_packet_data = 1'b0;
    clear              = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    store_tx_data = 1'b1;
    tx_data_in    = b;
    tick();
    store_tx_data = 1'b0;
  endtask

  task automatic pop();
    get_tx_packet_data = 1'b1;
    tick();
    get_tx_packet_data = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    tx_data_in = 8'h00;
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    checks++;
    if (tx_packet_data_size !== 7'd0 || buffer_empty !== 1'b1 || buffer_full !== 1'b0 ||
        tx_packet_data !== 8'h00 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: size=%0d empty=%b full=%b data=%h ovf=%b unf=%b, required 0 1 0 00 0 0",
               tx_packet_data_size, buffer_empty, buffer_full, tx_packet_data, overflow_err, underflow_err);
    end
  endtask

  task automatic test_store_pop();
    logic [7:0] vals [3];
    vals[0] = 8'hA5; vals[1] = 8'h5A; vals[2] = 8'h3C;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      push(vals[i]);
      checks++;
      if (tx_packet_data_size !== 7'(i + 1)) begin
        errors++;
        $display("FAIL store_size[%0d]: got %0d required %0d", i, tx_packet_data_size, i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_packet_data !== vals[i]) begin
        errors++;
        $display("FAIL pop_data[%0d]: got %h required %h", i, tx_packet_data, vals[i]);
      end
      pop();
    end
    checks++;
    if (buffer_empty !== 1'b1 || tx_packet_data_size !== 7'd0) begin
      errors++;
      $display("FAIL pop_empty: empty=%b size=%0d required 1 0", buffer_empty, tx_packet_data_size);
    end
  endtask

  task automatic test_full_overflow();
    do_clear();
    for (int i = 0; i < 64; i++) push(8'(i));
    checks++;
    if (buffer_full !== 1'b1 || tx_packet_data_size !== 7'd64 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL full: full=%b size=%0d ovf=%b required 1 64 0", buffer_full, tx_packet_data_size, overflow_err);
    end
    push(8'hFF);
    checks++;
    if (overflow_err !== 1'b1 || tx_packet_data_size !== 7'd64) begin
      errors++;
      $display("FAIL overflow: ovf=%b size=%0d required 1 64", overflow_err, tx_packet_data_size);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (tx_packet_data !== 8'(i)) begin
        errors++;
        $display("FAIL drain[%0d]: got %h required %h", i, tx_packet_data, 8'(i));
      end
      pop();
    end
    checks++;
    if (buffer_empty !== 1'b1 || buffer_full !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: empty=%b full=%b unf=%b required 1 0 0", buffer_empty, buffer_full, underflow_err);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    push(8'h11);
    store_tx_data      = 1'b1;
    tx_data_in         = 8'h22;
    get_tx_packet_data = 1'b1;
    tick();
    idle();
    checks++;
    if (tx_packet_data_size !== 7'd1 || tx_packet_data !== 8'h22) begin
      errors++;
      $display("FAIL simul_rw: size=%0d data=%h required 1 22", tx_packet_data_size, tx_packet_data);
    end
    pop();
    checks++;
    if (buffer_empty !== 1'b1 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL last_pop: empty=%b unf=%b required 1 0", buffer_empty, underflow_err);
    end
    pop();
    checks++;
    if (underflow_err !== 1'b1 || tx_packet_data !== 8'h00 || tx_packet_data_size !== 7'd0) begin
      errors++;
      $display("FAIL underflow: unf=%b data=%h size=%0d required 1 00 0", underflow_err, tx_packet_data, tx_packet_data_size);
    end
    // Write into empty with a same-cycle pop: write lands, pop is an underflow.
    do_clear();
    store_tx_data      = 1'b1;
    tx_data_in         = 8'h77;
    get_tx_packet_data = 1'b1;
    tick();
    idle();
    checks++;
    if (tx_packet_data_size !== 7'd1 || tx_packet_data !== 8'h77 || underflow_err !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw: size=%0d data=%h unf=%b required 1 77 1", tx_packet_data_size, tx_packet_data, underflow_err);
    end
  endtask

  task automatic test_wrap();
    do_clear();
    for (int i = 0; i < 60; i++) push(8'(i + 100));
    for (int i = 0; i < 60; i++) pop();
    for (int i = 0; i < 10; i++) push(8'hB0 + 8'(i));
    checks++;
    if (tx_packet_data_size !== 7'd10) begin
      errors++;
      $display("FAIL wrap_size: got %0d required 10", tx_packet_data_size);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx_packet_data !== 8'hB0 + 8'(i)) begin
        errors++;
        $display("FAIL wrap_data[%0d]: got %h required %h", i, tx_packet_data, 8'hB0 + 8'(i));
      end
      pop();
    end
    checks++;
    if (tx_packet_data_size !== 7'd0 || buffer_empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end: size=%0d empty=%b required 0 1", tx_packet_data_size, buffer_empty);
    end
  endtask

  task automatic test_clear_reset();
    do_clear();
    for (int i = 0; i < 64; i++) push(8'(i));
    push(8'hEE);
    for (int i = 0; i < 64; i++) pop();
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    checks++;
    if (overflow_err !== 1'b1 || tx_packet_data_size !== 7'd5 || tx_packet_data !== 8'hC0) begin
      errors++;
      $display("FAIL pre_clear: ovf=%b size=%0d data=%h required 1 5 c0", overflow_err, tx_packet_data_size, tx_packet_data);
    end
    clear         = 1'b1;
    store_tx_data = 1'b1;
    tx_data_in    = 8'hDD;
    tick();
    idle();
    checks++;
    if (tx_packet_data_size !== 7'd0 || buffer_empty !== 1'b1 || overflow_err !== 1'b0 || tx_packet_data !== 8'h00) begin
      errors++;
      $display("FAIL clear: size=%0d empty=%b ovf=%b data=%h required 0 1 0 00", tx_packet_data_size, buffer_empty, overflow_err, tx_packet_data);
    end
    for (int i = 0; i < 3; i++) push(8'hD0 + 8'(i));
    pop();
    pop();
    pop();
    pop();
    checks++;
    if (underflow_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_unf: got %b required 1", underflow_err);
    end
    for (int i = 0; i < 3; i++) push(8'hE0 + 8'(i));
    pop();
    n_rst              = 1'b0;
    get_tx_packet_data = 1'b1;
    store_tx_data      = 1'b1;
    tx_data_in         = 8'h99;
    tick();
    n_rst = 1'b1;
    idle();
    checks++;
    if (tx_packet_data_size !== 7'd0 || buffer_empty !== 1'b1 || overflow_err !== 1'b0 ||
        underflow_err !== 1'b0 || tx_packet_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_pulse: size=%0d empty=%b ovf=%b unf=%b data=%h required 0 1 0 0 00",
               tx_packet_data_size, buffer_empty, overflow_err, underflow_err, tx_packet_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_rst  = 1'b1;
    idle();
    tx_data_in = 8'h00;
    test_reset();
    test_store_pop();
    test_full_overflow();
    test_back_to_back();
    test_wrap();
    test_clear_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
